ft232h_device: RTL and testbench

- Device-side model of the FT232H FIFO port, used for on-FPGA loopback and self-test. It drives txe_n and rxf_n, obeys wr_n, oe_n and rd_n, and sources or sinks adbus.
- It is the opposite end of the host-side FT232H bridge, standing in for the physical chip.
- A "PC-side" byte stream fills an RX FIFO, which the bridge reads over adbus.
- Bytes the bridge writes over adbus land in a TX FIFO, which drains to a PC-side output stream.

---
 rtl/ft232h_device_pkg.sv | 19 +
 rtl/ft232h_device_if.sv | 28 ++
 rtl/ft232h_device_byte_fifo.sv | 71 +++++++
 rtl/ft232h_device.sv | 97 +++++++++
 tb/tb_ft232h_device.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ft232h_device_pkg.sv
// Shared constants and types for the FT232H device-side FIFO model.
package ft232h_device_pkg;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    localparam int unsigned FT_BYTE_W = 8;

    typedef logic [FT_BYTE_W-1:0] ft_byte_t;

    typedef struct packed {
        logic rd_underflow;
        logic wr_overflow;
        logic contention;
    } ft_err_t;

endpackage

// File: rtl/ft232h_device_if.sv
// PC-side streams and FT232H FIFO-port strobes/flags; adbus stays a module port.
interface ft232h_device_if
    import ft232h_device_pkg::*;
();

    logic     h_valid;
    logic     h_ready;
    ft_byte_t h_data;
    logic     o_valid;
    logic     o_ready;
    ft_byte_t o_data;
    logic     rxf_n;
    logic     oe_n;
    logic     rd_n;
    logic     txe_n;
    logic     wr_n;

    modport slave (
        input  h_valid, h_data, o_ready, oe_n, rd_n, wr_n,
        output h_ready, o_valid, o_data, rxf_n, txe_n
    );

    modport master (
        output h_valid, h_data, o_ready, oe_n, rd_n, wr_n,
        input  h_ready, o_valid, o_data, rxf_n, txe_n
    );

endinterface

// File: rtl/ft232h_device_byte_fifo.sv
// Synchronous byte FIFO with registered head and exposed next-state count.
module ft232h_device_byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_W-1:0]     din_i,
    output logic [DATA_W-1:0]     dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic [DEPTH_LOG2:0]   count_next_o
);

    localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  wr_en, rd_en;

    always_comb begin
        full_o   = (count_q == FULL_CNT);
        empty_o  = (count_q == '0);
        wr_en    = push_i & ~full_o;
        rd_en    = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (DEPTH_LOG2)'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + (DEPTH_LOG2)'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/ft232h_device.sv
// Device-side FT232H FIFO-port model: RX/TX byte FIFOs, flags, adbus driver, error pulse.
module ft232h_device
    import ft232h_device_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = FT_BYTE_W
) (
    input  logic                clk,
    input  logic                rst,
    ft232h_device_if.slave      bus,
    inout  wire [DATA_W-1:0]    adbus,
    output logic [DEPTH_LOG2:0] rx_level,
    output logic [DEPTH_LOG2:0] tx_level,
    output logic                proto_err
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

    logic                rxf_n_q, rxf_n_d;
    logic                txe_n_q, txe_n_d;
    logic                rdy_q;
    logic                proto_err_q, proto_err_d;
    ft_err_t             err;

    logic                rx_push, rx_pop, rx_full, rx_empty;
    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0]   rx_head, tx_head;
    logic [DEPTH_LOG2:0] rx_cnt_next, tx_cnt_next;
    logic                drive;

    ft232h_device_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_rx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (rx_push),
        .pop_i        (rx_pop),
        .din_i        (bus.h_data),
        .dout_o       (rx_head),
        .full_o       (rx_full),
        .empty_o      (rx_empty),
        .count_o      (rx_level),
        .count_next_o (rx_cnt_next)
    );

    ft232h_device_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (tx_push),
        .pop_i        (tx_pop),
        .din_i        (adbus),
        .dout_o       (tx_head),
        .full_o       (tx_full),
        .empty_o      (tx_empty),
        .count_o      (tx_level),
        .count_next_o (tx_cnt_next)
    );

    always_comb begin
        err.rd_underflow = (bus.rd_n == ENABLE_N) && (rxf_n_q == DISABLE_N);
        err.wr_overflow  = (bus.wr_n == ENABLE_N) && (txe_n_q == DISABLE_N);
        err.contention   = (bus.wr_n == ENABLE_N) && (bus.oe_n == ENABLE_N);

        // Pop/capture qualifiers exclude every violating combination, so
        // an offending strobe never disturbs FIFO state.
        rx_push = bus.h_valid & rdy_q & ~rx_full;
        rx_pop  = ~bus.rd_n & ~bus.oe_n & bus.wr_n & ~rxf_n_q;
        tx_push = ~bus.wr_n & bus.oe_n & ~txe_n_q & ~tx_full;
        tx_pop  = bus.o_ready & ~tx_empty;
        drive   = ~bus.oe_n & bus.wr_n & ~rxf_n_q & ~rx_empty;

        rxf_n_d     = (rx_cnt_next == '0) ? DISABLE_N : ENABLE_N;
        txe_n_d     = (tx_cnt_next == FULL_CNT) ? DISABLE_N : ENABLE_N;
        proto_err_d = |err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxf_n_q     <= DISABLE_N;
            txe_n_q     <= DISABLE_N;
            rdy_q       <= DISABLE;
            proto_err_q <= DISABLE;
        end else begin
            rxf_n_q     <= rxf_n_d;
            txe_n_q     <= txe_n_d;
            rdy_q       <= ENABLE;
            proto_err_q <= proto_err_d;
        end
    end

    assign adbus       = drive ? rx_head : 'z;
    assign bus.rxf_n   = rxf_n_q;
    assign bus.txe_n   = txe_n_q;
    assign bus.h_ready = rdy_q & ~rx_full;
    assign bus.o_valid = ~tx_empty;
    assign bus.o_data  = tx_head;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_ft232h_device.sv
// Scoreboard bench for ft232h_device: queued expectations checked by RX/TX monitors.
module tb_ft232h_device;

    logic       clk;
    logic       rst;
    logic       tb_drv;
    logic [7:0] tb_ad;
    wire  [7:0] adbus;
    logic [4:0] rx_level, tx_level;
    logic       proto_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_rx[$];
    logic [7:0]  exp_tx[$];

    ft232h_device_if bus ();

    ft232h_device #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .adbus     (adbus),
        .rx_level  (rx_level),
        .tx_level  (tx_level),
        .proto_err (proto_err)
    );

    // Released bus reads back as all ones; test bytes avoid 8'hFF.
    pullup (adbus);
    assign adbus = tb_drv ? tb_ad : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !bus.oe_n && !bus.rd_n && bus.wr_n && !bus.rxf_n) begin
            if (exp_rx.size() == 0) begin
                chk("rx_unexpected_read", {24'd0, adbus}, 32'hdead);
            end else begin
                chk("rx_adbus", {24'd0, adbus}, {24'd0, exp_rx.pop_front()});
            end
        end
        if (!rst && bus.o_valid && bus.o_ready) begin
            if (exp_tx.size() == 0) begin
                chk("tx_unexpected_byte", {24'd0, bus.o_data}, 32'hdead);
            end else begin
                chk("tx_o_data", {24'd0, bus.o_data}, {24'd0, exp_tx.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int unsigned n;
        rst = 1'b1;
        tb_drv = 1'b0;
        tb_ad = 8'h00;
        bus.h_valid = 1'b0;
        bus.h_data = 8'h00;
        bus.o_ready = 1'b0;
        bus.oe_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        step();
        step();
        chk("rst_rxf_n", {31'd0, bus.rxf_n}, 1);
        chk("rst_txe_n", {31'd0, bus.txe_n}, 1);
        chk("rst_h_ready", {31'd0, bus.h_ready}, 0);
        chk("rst_o_valid", {31'd0, bus.o_valid}, 0);
        chk("rst_proto_err", {31'd0, proto_err}, 0);
        chk("rst_adbus_z", {24'd0, adbus}, 32'hff);
        rst = 1'b0;
        step();
        chk("rel_txe_n", {31'd0, bus.txe_n}, 0);
        chk("rel_h_ready", {31'd0, bus.h_ready}, 1);
        chk("rel_rx_level", {27'd0, rx_level}, 0);
        chk("rel_tx_level", {27'd0, tx_level}, 0);

        // Reset in the middle of a transfer drops the buffered byte
        bus.h_valid = 1'b1; bus.h_data = 8'h5A;
        step();
        bus.h_valid = 1'b0;
        chk("mr_rx_level", {27'd0, rx_level}, 1);
        bus.oe_n = 1'b0;
        #1;
        chk("mr_adbus_drive", {24'd0, adbus}, 32'h5a);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mr_rxf_n", {31'd0, bus.rxf_n}, 1);
        chk("mr_txe_n", {31'd0, bus.txe_n}, 1);
        chk("mr_adbus_z", {24'd0, adbus}, 32'hff);
        chk("mr_rx_level", {27'd0, rx_level}, 0);
        bus.oe_n = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("mr_rel_txe_n", {31'd0, bus.txe_n}, 0);
        chk("mr_rel_h_ready", {31'd0, bus.h_ready}, 1);

        // Read stream
        bus.h_valid = 1'b1; bus.h_data = 8'hA5; exp_rx.push_back(8'hA5);
        step();
        bus.h_data = 8'h3C; exp_rx.push_back(8'h3C);
        step();
        bus.h_valid = 1'b0;
        chk("rd_rx_level", {27'd0, rx_level}, 2);
        chk("rd_rxf_n_low", {31'd0, bus.rxf_n}, 0);
        bus.oe_n = 1'b0; bus.rd_n = 1'b0;
        step();
        step();
        chk("rd_rxf_n_high", {31'd0, bus.rxf_n}, 1);
        chk("rd_adbus_z", {24'd0, adbus}, 32'hff);
        bus.rd_n = 1'b1; bus.oe_n = 1'b1;
        step();
        chk("rd_no_err", {31'd0, proto_err}, 0);

        // Write stream with draining consumer
        bus.o_ready = 1'b1;
        tb_drv = 1'b1; bus.wr_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tb_ad = 8'h11 + 8'(i);
            exp_tx.push_back(tb_ad);
            step();
        end
        bus.wr_n = 1'b1; tb_drv = 1'b0;
        n = 0;
        while (tx_level != 0 && n < 20) begin step(); n++; end
        step();
        chk("wr_tx_level", {27'd0, tx_level}, 0);
        chk("wr_tx_drained", exp_tx.size(), 0);

        // TX full, then overflow
        bus.o_ready = 1'b0;
        tb_drv = 1'b1; bus.wr_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tb_ad = 8'h20 + 8'(i);
            exp_tx.push_back(tb_ad);
            step();
        end
        chk("full_txe_n", {31'd0, bus.txe_n}, 1);
        chk("full_tx_level", {27'd0, tx_level}, 16);
        tb_ad = 8'h99;
        step();
        chk("ovf_proto_err", {31'd0, proto_err}, 1);
        chk("ovf_tx_level", {27'd0, tx_level}, 16);
        bus.wr_n = 1'b1; tb_drv = 1'b0;
        step();
        chk("ovf_pulse_end", {31'd0, proto_err}, 0);
        bus.o_ready = 1'b1;
        n = 0;
        while (tx_level != 0 && n < 40) begin step(); n++; end
        step();
        chk("ovf_tx_level_0", {27'd0, tx_level}, 0);
        chk("ovf_no_loss", exp_tx.size(), 0);
        chk("ovf_txe_n", {31'd0, bus.txe_n}, 0);

        // Concurrent RX push and pop
        bus.h_valid = 1'b1; bus.h_data = 8'h40; exp_rx.push_back(8'h40);
        step();
        bus.h_valid = 1'b0;
        chk("cc_rx_level_1", {27'd0, rx_level}, 1);
        bus.h_valid = 1'b1; bus.h_data = 8'h77; exp_rx.push_back(8'h77);
        bus.oe_n = 1'b0; bus.rd_n = 1'b0;
        step();
        bus.h_valid = 1'b0; bus.rd_n = 1'b1;
        chk("cc_rx_level", {27'd0, rx_level}, 1);
        chk("cc_rxf_n", {31'd0, bus.rxf_n}, 0);
        chk("cc_head", {24'd0, adbus}, 32'h77);

        // Bus contention
        bus.wr_n = 1'b0;
        #1;
        chk("ct_adbus_z", {24'd0, adbus}, 32'hff);
        step();
        chk("ct_proto_err", {31'd0, proto_err}, 1);
        chk("ct_tx_level", {27'd0, tx_level}, 0);
        chk("ct_rx_level", {27'd0, rx_level}, 1);
        bus.wr_n = 1'b1;
        #1;
        chk("ct_head_kept", {24'd0, adbus}, 32'h77);
        bus.rd_n = 1'b0;
        step();
        bus.rd_n = 1'b1; bus.oe_n = 1'b1;
        chk("ct_rx_level_0", {27'd0, rx_level}, 0);

        // Read underflow
        bus.rd_n = 1'b0;
        step();
        bus.rd_n = 1'b1;
        chk("uf_proto_err", {31'd0, proto_err}, 1);
        chk("uf_rx_level", {27'd0, rx_level}, 0);
        step();
        chk("uf_pulse_end", {31'd0, proto_err}, 0);
        chk("rx_all_read", exp_rx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
